cpu_boot_loader: RTL
====================

Name: cpu_boot_loader

Overview:
- Boot/program-load controller for cpu_16bit.
- Accepts a length-prefixed instruction stream from a host over a valid/ready handshake, then drives the CPU's instruction-load port (instruction_in, load_address, load_instruction).
- Optionally pads the unused instruction memory with a fill word.
- Holds the CPU in pc_reset until loading completes, then releases it. Supports reload on request.

Parameters:
- ADDR_W, 8, instruction memory address width; DEPTH = 2**ADDR_W words.
- PAD_EN, 1, when 1, write PAD_WORD to addresses N..DEPTH-1 after the payload.
- PAD_WORD, 16'h0000, fill word used for padding (NOP encoding).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  16  host word: the first word is length N, then N instruction words.
- in_valid  input  1  host word valid.
- in_ready  output  1  controller can accept in_data.
- reload  input  1  single-cycle request to re-enter load mode (honoured in RUN and ERROR only).
- instruction_out  output  16  to the cpu_16bit instruction_in port.
- load_address  output  16  to cpu_16bit load_address; bits [15:ADDR_W] are always 0.
- load_instruction  output  1  write strobe to the CPU instruction memory.
- pc_reset  output  1  to cpu_16bit pc_reset; 1 holds the CPU in reset.
- busy  output  1  1 in LOAD, FILL and SETTLE.
- done  output  1  1 in RUN.
- error  output  1  1 in ERROR.

Behaviour:
- Handshake and outputs:
  - A word is accepted on a rising edge where in_valid && in_ready.
  - in_data is sampled only on acceptance.
  - All outputs are registered.
- Reset values:
  - State = WAIT_LEN, pc_reset = 1, load_instruction = 0, load_address = 0, instruction_out = 0.
  - busy = 0, done = 0, error = 0.
  - Word counter cnt = 0, length register len = 0.
- State WAIT_LEN: in_ready = 1, pc_reset = 1. On acceptance, len <= in_data and cnt <= 0.
  - in_data == 0: go to FILL if PAD_EN, else SETTLE.
  - in_data > DEPTH: go to ERROR.
  - Otherwise: go to LOAD.
- State LOAD: in_ready = 1. On acceptance:
  - Next cycle: load_instruction = 1, instruction_out = in_data, load_address = cnt. cnt increments.
  - When the accepted word is word len-1:
    - go to FILL if PAD_EN && len < DEPTH;
    - else go to SETTLE.
  - In_valid gaps insert idle cycles; load_instruction = 0 during gaps.
  - Latency from accept to strobe is 1 cycle.
- State FILL: in_ready = 0.
  - Every cycle: load_instruction = 1, instruction_out = PAD_WORD, load_address = cnt, cnt increments.
  - After the strobe for address DEPTH-1, go to SETTLE.
  - Fill takes exactly DEPTH-len cycles.
- State SETTLE: one cycle. in_ready = 0, load_instruction = 0, pc_reset = 1. This guarantees the last write commits before the CPU fetches. Then go to RUN.
- State RUN: pc_reset = 0, done = 1, in_ready = 0, load_instruction = 0.
  - reload = 1: next state WAIT_LEN; pc_reset = 1 on the following cycle.
- State ERROR: pc_reset = 1, error = 1, in_ready = 0, no writes.
  - Exit only via reset or reload (reload goes to WAIT_LEN and clears error).
- Boundaries:
  - len == DEPTH is legal: no FILL.
  - cnt is ADDR_W+1 bits and never wraps; no write is issued at address >= DEPTH.
  - reload in WAIT_LEN, LOAD, FILL or SETTLE is ignored.
  - reset at any point aborts immediately: the next cycle has no strobe and pc_reset = 1.
  - in_valid held high while in_ready = 0 is not consumed.
- load_instruction is never high in the same cycle as pc_reset = 0.

Decomposition:
- Shared package cpu_boot_pkg:
  - state encoding enum: WAIT_LEN, LOAD, FILL, SETTLE, RUN, ERROR;
  - the default NOP/PAD_WORD constant;
  - the 16-bit word width constant shared with cpu_16bit.
- One sub-module, boot_addr_counter: cnt register with clear, enable and a terminal flag (cnt == len-1 or cnt == DEPTH-1). All other logic lives in the FSM.

Test Plan:
- Basic load: ADDR_W = 4, PAD_EN = 0, stream 3, A001, A002, A003 with in_valid continuous.
  - Required: strobes at addresses 0, 1, 2 with those data on consecutive cycles.
  - One SETTLE cycle, then pc_reset = 0 and done = 1.
- Padding: ADDR_W = 4, PAD_EN = 1, PAD_WORD = 0000, stream 2, 1111, 2222.
  - Required: writes at 0 and 1, then 14 fill strobes at addresses 2..15 with data 0000.
  - pc_reset falls 1 cycle after the address-15 strobe.
- Bubbles: same as basic load, with in_valid low 2 cycles between each data word.
  - Required: no strobe during gaps; addresses still 0, 1, 2; in_ready stays 1.
- Boundaries, ADDR_W = 4:
  - length 16 with 16 words: no FILL; last strobe at address 15.
  - length 17: ERROR, error = 1, no strobes, pc_reset stays 1.
  - length 0 with PAD_EN = 0: RUN after SETTLE with zero writes.
- Reload: in RUN, pulse reload.
  - Required: pc_reset = 1 and in_ready = 1 next cycle; a new stream 1, BEEF writes BEEF at address 0.
  - reload pulsed during LOAD has no effect.
- Reset mid-load: assert reset after 2 of 5 words.
  - Required: next cycle load_instruction = 0, state WAIT_LEN, cnt = 0.
  - A new stream then loads starting at address 0.

Source files
------------

// File: rtl/cpu_boot_pkg.sv
// rtl/cpu_boot_pkg.sv - shared types and constants for the cpu_16bit boot loader
package cpu_boot_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic [2:0] {
        WAIT_LEN,
        LOAD,
        FILL,
        SETTLE,
        RUN,
        ERROR
    } boot_state_e;

endpackage

// File: rtl/boot_addr_counter.sv
// rtl/boot_addr_counter.sv - instruction write address counter with terminal detect
module boot_addr_counter #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic            fill_mode,
    input  logic [ADDR_W:0] len,
    output logic [ADDR_W:0] cnt,
    output logic            term
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'((1 << ADDR_W) - 1);

    logic [ADDR_W:0] cnt_d;
    logic [ADDR_W:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Payload ends at len-1; padding always runs to the top of memory.
    assign term = fill_mode ? (cnt_q == LAST_ADDR) : (cnt_q == len - 1'b1);
    assign cnt  = cnt_q;

endmodule

// File: rtl/cpu_boot_loader.sv
// rtl/cpu_boot_loader.sv - length-prefixed program loader driving the cpu_16bit load port
module cpu_boot_loader
    import cpu_boot_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter bit                PAD_EN   = 1'b1,
    parameter logic [WORD_W-1:0] PAD_WORD = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic [WORD_W-1:0] instruction_out,
    output logic [WORD_W-1:0] load_address,
    output logic              load_instruction,
    output logic              pc_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    boot_state_e       state_d, state_q;
    logic [ADDR_W:0]   len_d, len_q;
    logic [WORD_W-1:0] instr_d, instr_q;
    logic [WORD_W-1:0] addr_d, addr_q;
    logic              strobe_d, strobe_q;
    logic              in_ready_d, in_ready_q;
    logic              pc_reset_d, pc_reset_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              error_d, error_q;

    logic              accept;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_term;
    logic [ADDR_W:0]   cnt;

    boot_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .fill_mode (state_q == FILL),
        .len       (len_q),
        .cnt       (cnt),
        .term      (cnt_term)
    );

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        strobe_d = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            WAIT_LEN: begin
                if (accept) begin
                    len_d   = in_data[ADDR_W:0];
                    cnt_clr = 1'b1;
                    if (in_data == '0) begin
                        state_d = PAD_EN ? FILL : SETTLE;
                    end else if (32'(in_data) > DEPTH) begin
                        state_d = ERROR;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    strobe_d = 1'b1;
                    instr_d  = in_data;
                    addr_d   = WORD_W'(cnt);
                    cnt_en   = 1'b1;
                    if (cnt_term) begin
                        state_d = (PAD_EN && (len_q < DEPTH_W)) ? FILL : SETTLE;
                    end
                end
            end
            FILL: begin
                strobe_d = 1'b1;
                instr_d  = PAD_WORD;
                addr_d   = WORD_W'(cnt);
                cnt_en   = 1'b1;
                if (cnt_term) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = RUN;
            end
            RUN, ERROR: begin
                if (reload) begin
                    state_d = WAIT_LEN;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LEN;
            end
        endcase

        // Status outputs follow the next state so the CPU is released only once
        // the final write strobe has been presented while pc_reset is still high.
        in_ready_d = (state_d == WAIT_LEN) || (state_d == LOAD);
        busy_d     = (state_d == LOAD) || (state_d == FILL) || (state_d == SETTLE);
        done_d     = (state_d == RUN);
        error_d    = (state_d == ERROR);
        pc_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_LEN;
            len_q      <= '0;
            instr_q    <= '0;
            addr_q     <= '0;
            strobe_q   <= 1'b0;
            in_ready_q <= 1'b1;
            pc_reset_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            strobe_q   <= strobe_d;
            in_ready_q <= in_ready_d;
            pc_reset_q <= pc_reset_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign instruction_out  = instr_q;
    assign load_address     = addr_q;
    assign load_instruction = strobe_q;
    assign pc_reset         = pc_reset_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule
